// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// registers each fetched instruction with its PC into the IF/ID register.
module instr_fetch #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic                 r_out_valid;
  logic [INSTR_W-1:0]   r_out_instr;
  logic [ADDR_W-1:0]    r_out_pc;
  logic                 r_fault;
  logic [15:0]          r_fetch_count;

  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    w_pc_nxt;
  logic                 w_valid_nxt;
  logic [INSTR_W-1:0]   w_instr_nxt;
  logic [ADDR_W-1:0]    w_out_pc_nxt;
  logic                 w_fault_nxt;
  logic [15:0]          w_count_nxt;

  logic                 w_adv;
  logic                 w_legal;
  logic [ADDR_W:0]      w_pc_end;

  // Last byte of the fetched word, one bit wider so the bound never wraps.
  assign w_pc_end = {1'b0, r_pc} + (ADDR_W+1)'(3);
  assign w_legal  = (r_pc[1:0] == 2'b00) && (w_pc_end < (ADDR_W+1)'(MEM_SIZE));
  assign w_adv    = (r_state == RUN) && (!r_out_valid || out_ready);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_valid_nxt  = r_out_valid;
    w_instr_nxt  = r_out_instr;
    w_out_pc_nxt = r_out_pc;
    w_fault_nxt  = r_fault;
    w_count_nxt  = r_fetch_count;

    case (r_state)
      START:   w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = START;
    endcase

    if (redirect_valid && (r_state != FAULT)) begin
      w_pc_nxt    = redirect_pc;
      w_valid_nxt = 1'b0;
    end else if (w_adv) begin
      if (w_legal) begin
        w_instr_nxt  = imem_instr;
        w_out_pc_nxt = r_pc;
        w_valid_nxt  = 1'b1;
        w_pc_nxt     = r_pc + ADDR_W'(4);
        if (r_fetch_count != 16'hFFFF) begin
          w_count_nxt = r_fetch_count + 16'd1;
        end
      end else begin
        w_fault_nxt = 1'b1;
        w_state_nxt = FAULT;
        w_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= START;
      r_pc          <= ADDR_W'(RESET_PC);
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_pc      <= '0;
      r_fault       <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_out_valid   <= w_valid_nxt;
      r_out_instr   <= w_instr_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_fault       <= w_fault_nxt;
      r_fetch_count <= w_count_nxt;
    end
  end

  assign imem_addr   = r_pc;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations, then random traffic compared every cycle to a reference model.
module tb_instr_fetch;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned MEM_SIZE = 1024;

  logic               clk;
  logic               rst_n;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               fault;
  logic [15:0]        fetch_count;

  logic [INSTR_W-1:0] rom [0:255];

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  instr_fetch #(
    .ADDR_W(ADDR_W),
    .INSTR_W(INSTR_W),
    .RESET_PC(0),
    .MEM_SIZE(MEM_SIZE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .fault(fault),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: one 16-bit word per 4-byte slot; outside the array reads a marker.
  assign imem_instr = (imem_addr < 16'(MEM_SIZE)) ? rom[imem_addr[9:2]] : 16'hBAD0;

  // Reference model: the architectural fetch rules applied once per edge.
  bit                 m_started;
  int unsigned        m_pc;
  bit                 m_valid;
  logic [INSTR_W-1:0] m_instr;
  int unsigned        m_opc;
  bit                 m_fault;
  int unsigned        m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 0; m_pc = 0; m_valid = 0; m_instr = '0;
      m_opc = 0; m_fault = 0; m_cnt = 0;
    end else if (!m_started) begin
      if (redirect_valid) begin
        m_pc = redirect_pc;
        m_valid = 0;
      end
      m_started = 1;
    end else if (m_fault) begin
      // frozen until reset
    end else if (redirect_valid) begin
      m_pc = redirect_pc;
      m_valid = 0;
    end else if (!m_valid || out_ready) begin
      if ((m_pc % 4 == 0) && (m_pc + 3 < MEM_SIZE)) begin
        m_instr = rom[m_pc / 4];
        m_opc   = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 4) % 65536;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_fault = 1;
        m_valid = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model imem_addr", 32'(imem_addr), m_pc);
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      chk("model fault", 32'(fault), 32'(m_fault));
      chk("model fetch_count", 32'(fetch_count), m_cnt);
      chk("model out_pc", 32'(out_pc), m_opc);
      chk("model out_instr", 32'(out_instr), 32'(m_instr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
    rom[16] = 16'hA5A5; rom[254] = 16'h0FE0; rom[255] = 16'hFFC3;

    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #1 cmp_en = 1;
    tick(); tick();
    rst_n = 1'b1;

    // Startup and back-to-back delivery
    tick();
    chk("start valid", 32'(out_valid), 32'd0);
    chk("start addr", 32'(imem_addr), 32'd0);
    tick(); chk("seq pc0", {out_valid, out_pc, out_instr}, {1'b1, 16'h0000, 16'h1111});
    tick(); chk("seq pc4", {out_valid, out_pc, out_instr}, {1'b1, 16'h0004, 16'h2222});
    tick(); chk("seq pc8", {out_valid, out_pc, out_instr}, {1'b1, 16'h0008, 16'h3333});
    tick(); chk("seq pc12", {out_valid, out_pc, out_instr}, {1'b1, 16'h000C, 16'h4444});
    chk("seq count", 32'(fetch_count), 32'd4);

    // Stall holding out_pc=4
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick(); redirect_valid = 1'b0;
    chk("flush valid", 32'(out_valid), 32'd0);
    tick(); tick(); out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("stall hold", {out_valid, out_pc, imem_addr}, {1'b1, 16'h0004, 16'h0008});
    end
    out_ready = 1'b1;
    tick(); chk("stall release", {out_pc, out_instr}, {16'h0008, 16'h3333});

    // Redirect while stalled at out_pc=8
    out_ready = 1'b0;
    tick(); chk("stall at 8", {out_valid, out_pc}, {1'b1, 16'h0008});
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick(); redirect_valid = 1'b0; out_ready = 1'b1;
    chk("redir flush", {out_valid, imem_addr}, {1'b0, 16'h0040});
    tick(); chk("redir target", {out_valid, out_pc, out_instr}, {1'b1, 16'h0040, 16'hA5A5});

    // Run off the end of the ROM
    redirect_valid = 1'b1; redirect_pc = 16'd1016;
    tick(); redirect_valid = 1'b0;
    tick(); chk("end 1016", {out_pc, out_instr}, {16'd1016, 16'h0FE0});
    tick(); chk("end 1020", {out_valid, out_pc, out_instr, imem_addr}, {1'b1, 16'd1020, 16'hFFC3, 16'd1024});
    tick(); chk("end fault", {fault, out_valid}, {1'b1, 1'b0});
    chk("end count", 32'(fetch_count), 32'd10);
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick(); redirect_valid = 1'b0;
    chk("fault ignores redirect", {fault, out_valid, imem_addr}, {1'b1, 1'b0, 16'd1024});
    tick(); chk("fault sticky", {fault, out_valid}, {1'b1, 1'b0});

    // Asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    chk("async reset", {out_valid, fault, fetch_count, imem_addr}, {1'b0, 1'b0, 16'd0, 16'd0});
    tick(); rst_n = 1'b1;
    tick(); tick();
    chk("restart", {out_valid, out_pc, out_instr, fetch_count}, {1'b1, 16'h0000, 16'h1111, 16'd1});

    // Misaligned redirect faults on the next advance
    redirect_valid = 1'b1; redirect_pc = 16'h0006;
    tick(); redirect_valid = 1'b0;
    chk("misalign accept", {out_valid, fault, imem_addr}, {1'b0, 1'b0, 16'h0006});
    tick();
    chk("misalign fault", {fault, out_valid, imem_addr, fetch_count}, {1'b1, 1'b0, 16'h0006, 16'd1});

    // Random traffic against the model
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = 1'b0;
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ((m_fault && $urandom_range(0, 4) == 0) || $urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 9))
          0:       redirect_pc = 16'($urandom);
          1:       redirect_pc = 16'(1000 + 4 * $urandom_range(0, 5));
          default: redirect_pc = {6'd0, 8'($urandom_range(0, 255)), 2'b00};
        endcase
      end
      tick();
    end

    redirect_valid = 1'b0;
    tick();
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
